// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles every handshake signal around the instruction fetch stage:
//   - instruction memory request channel (imem_req/imem_addr/imem_ready)
//   - instruction memory response channel (imem_rvalid/imem_rdata)
//   - decode-side delivery channel (instr_valid/instr/instr_pc/instr_ready)
//   - execute-side redirect (redirect/redirect_pc)
// Modport master is the fetch unit itself; modport slave is everything around
// it (memory, decode and execute, or a testbench standing in for them).
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready,
               redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready,
               redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the single-cycle decode/execute datapath.
// Owns the word-addressed PC, issues requests to a variable-latency instruction
// memory, buffers in-order responses in a DEPTH-entry FIFO and hands them to
// decode with valid/ready. A redirect from execute flushes the buffer and
// arranges for every response still in flight to be thrown away.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   bus    - fetch_unit_if.master: imem request/response, decode delivery,
//            execute redirect
//
// Parameters:
//   AW       - PC / word address width
//   DEPTH    - buffer entries (power of 2, >= 2); also max in-flight requests
//   RESET_PC - PC loaded on reset
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int            AW       = 32,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] respPc_q, respPc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [31:0]   bufData_q [DEPTH];
    logic [AW-1:0] bufPc_q   [DEPTH];

    logic [CW:0]   inUse;
    logic          imemReq;
    logic          accept;
    logic          rspValid;
    logic          rspDrop;
    logic          push;
    logic          pop;
    logic          instrValid;

    // Credit check and handshake qualifiers. Every credit is either a word
    // sitting in the buffer or a request still in flight, so requesting only
    // while their sum is below DEPTH makes buffer overflow impossible.
    // A stray rvalid with nothing outstanding is ignored entirely, and a
    // response landing in a redirect cycle belongs to the wrong path.
    always_comb begin
        inUse      = {1'b0, occ_q} + {1'b0, outst_q};
        imemReq    = !reset && !bus.redirect && (inUse < (CW + 1)'(DEPTH));
        accept     = imemReq && bus.imem_ready;
        rspValid   = bus.imem_rvalid && (outst_q != '0);
        rspDrop    = rspValid && (drop_q != '0);
        push       = rspValid && !rspDrop && !bus.redirect;
        instrValid = !reset && (occ_q != '0);
        pop        = instrValid && bus.instr_ready && !bus.redirect;
    end

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instrValid;
    assign bus.instr       = bufData_q[head_q];
    assign bus.instr_pc    = bufPc_q[head_q];

    // Next-state for PCs, counters and buffer pointers. Redirect overrides
    // everything else: the buffer empties and the drop count is loaded with
    // whatever is still outstanding once this cycle's response is retired,
    // so every wrong-path word still coming back gets discarded.
    always_comb begin
        pc_d     = pc_q;
        respPc_d = respPc_q;
        occ_d    = occ_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        head_d   = head_q;
        tail_d   = tail_q;

        if (accept) begin
            outst_d = outst_d + CW'(1);
            pc_d    = pc_q + AW'(1);
        end
        if (rspValid) begin
            outst_d = outst_d - CW'(1);
        end

        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            respPc_d = bus.redirect_pc;
            occ_d    = '0;
            head_d   = '0;
            tail_d   = '0;
            drop_d   = outst_d;
        end else begin
            if (rspDrop) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                respPc_d = respPc_q + AW'(1);
                tail_d   = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + CW'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - CW'(1);
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            respPc_q <= RESET_PC;
            occ_q    <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            respPc_q <= respPc_d;
            occ_q    <= occ_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    // Buffer storage needs no reset: occupancy alone decides what is valid.
    // Each entry carries its own PC so decode sees which address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            bufData_q[tail_q] <= bus.imem_rdata;
            bufPc_q[tail_q]   <= respPc_q;
        end
    end

    // Occupancy can never exceed DEPTH because of the credit check above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (occ_q <= CW'(DEPTH));
        end
    end

endmodule
